// File: rtl/bm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bm_pkg
// Brief    : Shared state encoding and BRAM address-field widths for the
//            block-matcher read path and bit_pixel_rotator_bram.
// Revision : 1.0 - initial release
// ============================================================================
package bm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } bm_state_t;

    localparam int c_buf_w   = 1;
    localparam int c_third_w = 2;
    localparam int c_word_w  = 16;
    localparam int c_addr_w  = c_buf_w + c_third_w + c_word_w;
    localparam int c_data_w  = 16;
    localparam int c_img_w   = 4;
    // Output queue entry: data, third index, start-of-third, end-of-third
    localparam int c_entry_w = c_data_w + c_third_w + 2;

    function automatic logic [c_addr_w-1:0] make_addr(
        input logic                 buf_sel,
        input logic [c_third_w-1:0] third,
        input logic [c_word_w-1:0]  word
    );
        return {buf_sel, third, word};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bm_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bm_rd_skid_fifo
// Brief    : Two-entry in-order queue; head is presented combinationally and
//            stays put until popped.
// Revision : 1.0 - initial release
// ============================================================================
module bm_rd_skid_fifo
    import bm_pkg::*;
#(
    parameter int WIDTH = c_entry_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/bm_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bm_read_scheduler
// Brief    : Streams each completed three-third set out of the ping-pong BRAM
//            to the block matcher, one word per clock under backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module bm_read_scheduler
    import bm_pkg::*;
#(
    parameter int third_cols = 240,
    parameter int third_rows = 480,
    parameter int num_pix    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [c_img_w-1:0]   image_number,
    output logic [c_addr_w-1:0]  rd_addr,
    output logic                 rd_en,
    input  logic [c_data_w-1:0]  rd_data,
    output logic [c_data_w-1:0]  pix_out,
    output logic                 pix_out_valid,
    input  logic                 pix_out_ready,
    output logic [c_third_w-1:0] third_out,
    output logic                 sof_out,
    output logic                 eof_out,
    output logic                 busy,
    output logic                 overrun
);

    localparam int c_wr_cols         = third_cols / num_pix;
    localparam int c_words_per_third = c_wr_cols * third_rows;
    localparam logic [c_word_w-1:0]  c_last_word  = c_word_w'(c_words_per_third - 1);
    localparam logic [c_third_w-1:0] c_last_third = 2'd2;

    bm_state_t             r_state;
    bm_state_t             w_state_next;
    logic                  r_rd_buf;
    logic [c_img_w-1:0]    r_rd_image;
    logic [c_third_w-1:0]  r_third;
    logic [c_word_w-1:0]   r_word;
    logic                  r_inflight;
    logic [c_third_w-1:0]  r_if_third;
    logic                  r_if_sof;
    logic                  r_if_eof;
    logic                  r_overrun;

    logic                  w_pop;
    logic                  w_rd_en;
    logic                  w_last_word;
    logic                  w_set_done;
    logic                  w_drained;
    logic [2:0]            w_occupancy;
    logic [c_img_w-1:0]    w_lag;
    logic [1:0]            w_fifo_count;
    logic                  w_head_valid;
    logic [c_entry_w-1:0]  w_head;
    logic [c_entry_w-1:0]  w_push_data;

    assign w_pop       = w_head_valid & pix_out_ready;
    // Credit check counts the read already in flight so the queue never overflows
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en     = (r_state == ST_READ) && (w_occupancy < 3'd2);
    assign w_last_word = (r_word == c_last_word);
    assign w_set_done  = w_rd_en & w_last_word & (r_third == c_last_third);
    assign w_drained   = (w_fifo_count == 2'd0) && !r_inflight;
    assign w_lag       = image_number - r_rd_image;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (image_number != r_rd_image) begin
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (w_set_done) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_buf   <= 1'b0;
            r_rd_image <= '0;
            r_third    <= '0;
            r_word     <= '0;
            r_inflight <= 1'b0;
            r_if_third <= '0;
            r_if_sof   <= 1'b0;
            r_if_eof   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_if_third <= r_third;
                r_if_sof   <= (r_word == '0);
                r_if_eof   <= w_last_word;
            end

            if (r_state == ST_IDLE) begin
                r_third <= '0;
                r_word  <= '0;
            end else if (w_rd_en) begin
                if (w_last_word) begin
                    r_word  <= '0;
                    r_third <= (r_third == c_last_third) ? 2'd0 : r_third + 2'd1;
                end else begin
                    r_word <= r_word + 16'd1;
                end
            end

            // Set fully handed off: move to the writer's other buffer
            if ((r_state == ST_DRAIN) && w_drained) begin
                r_rd_buf   <= ~r_rd_buf;
                r_rd_image <= r_rd_image + 4'd1;
            end

            if (w_lag >= 4'd2) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_push_data = {rd_data, r_if_third, r_if_sof, r_if_eof};

    bm_rd_skid_fifo #(
        .WIDTH (c_entry_w)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (pix_out_ready),
        .o_data  (w_head),
        .o_valid (w_head_valid),
        .o_count (w_fifo_count)
    );

    assign {pix_out, third_out, sof_out, eof_out} = w_head;
    assign pix_out_valid = w_head_valid;
    assign rd_en         = w_rd_en;
    assign rd_addr       = make_addr(r_rd_buf, r_third, r_word);
    assign busy          = (r_state != ST_IDLE);
    assign overrun       = r_overrun;

endmodule
`default_nettype wire
